// File: rtl/pwm_bank_pkg.sv
// Shared types and constants for the multi-channel PWM bank.
// Step divisor table is an elaboration-time constant; no runtime latency.
// No flow control here; types only.
package pwm_bank_pkg;

    localparam int STEPS  = 100;
    localparam int DUTY_W = 7;
    localparam int CH_W   = 4;

    typedef struct packed {
        logic [DUTY_W-1:0] duty;
        logic [1:0]        pow2;
        logic [1:0]        pow5;
    } cmd_t;

    // Clocks per step: max(1, floor(clk / (STEPS * base * 2^p2 * 5^p5)))
    function automatic longint div_calc(input longint clk_freq, input longint base_freq,
                                        input int p2, input int p5);
        longint den;
        longint q;
        den = longint'(STEPS) * base_freq * (64'd1 << p2);
        for (int k = 0; k < p5; k++) begin
            den = den * 5;
        end
        q = clk_freq / den;
        return (q < 1) ? 64'd1 : q;
    endfunction

endpackage

// File: rtl/pwm_bank_ctrl_if.sv
// Command bus into the PWM bank: valid/ready plus a registered reject pulse.
// Latency: ready is combinational from reset; cmd_err arrives one cycle after the command.
// Backpressure: none, ready stays high outside reset.
interface pwm_bank_ctrl_if;
    import pwm_bank_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CH_W-1:0]   cmd_ch;
    logic [DUTY_W-1:0] cmd_duty;
    logic [1:0]        cmd_pow2;
    logic [1:0]        cmd_pow5;
    logic              cmd_imm;
    logic              cmd_err;

    modport master (
        output cmd_valid, cmd_ch, cmd_duty, cmd_pow2, cmd_pow5, cmd_imm,
        input  cmd_ready, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_duty, cmd_pow2, cmd_pow5, cmd_imm,
        output cmd_ready, cmd_err
    );

endinterface

// File: rtl/pwm_bank_ctrl_channel.sv
// One PWM channel: prescaler/step timebase, shadow/active settings, pend and period pulse.
// Latency: pwm lags the counters by one cycle; period pulse is combinational on the boundary cycle.
// Backpressure: none; PWM_BANK_PHASE_STAGGER_EN offsets the initial step by channel index.
module pwm_channel
    import pwm_bank_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BASE_FREQ = 100,
    parameter int DIV_W     = 16,
    parameter int N_CH      = 4,
    parameter int IDX       = 0
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_en,
    input  logic i_wr_vld,
    input  logic i_wr_imm,
    input  cmd_t i_wr_dat,
    output logic o_pwm,
    output logic o_pend,
    output logic o_period
);

`ifdef PWM_BANK_PHASE_STAGGER_EN
    localparam logic [DUTY_W-1:0] STEP_INIT = DUTY_W'((IDX * STEPS) / N_CH);
`else
    localparam logic [DUTY_W-1:0] STEP_INIT = '0;
`endif
    localparam logic [DUTY_W-1:0] STEP_LAST = DUTY_W'(STEPS - 1);

    logic [DIV_W-1:0] w_div_tab [16];

    for (genvar k = 0; k < 16; k++) begin : g_div
        localparam logic [DIV_W-1:0] DIV_K = DIV_W'(div_calc(CLK_FREQ, BASE_FREQ, k / 4, k % 4));
        assign w_div_tab[k] = DIV_K;
    end

    cmd_t              r_act;
    cmd_t              r_shd;
    logic              r_pend;
    logic              r_pwm;
    logic [DIV_W-1:0]  r_presc;
    logic [DUTY_W-1:0] r_step;

    logic [DIV_W-1:0]  w_div;
    logic              w_presc_wrap;
    logic              w_bnd;

    assign w_div        = w_div_tab[{r_act.pow2, r_act.pow5}];
    assign w_presc_wrap = (r_presc == (w_div - DIV_W'(1)));
    assign w_bnd        = rstn & i_en & w_presc_wrap & (r_step == STEP_LAST);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_act   <= '0;
            r_shd   <= '0;
            r_pend  <= 1'b0;
            r_pwm   <= 1'b0;
            r_presc <= '0;
            r_step  <= STEP_INIT;
        end else begin
            r_pwm <= i_en & (r_step < r_act.duty);
            if (i_en) begin
                if (w_presc_wrap) begin
                    r_presc <= '0;
                    r_step  <= (r_step == STEP_LAST) ? '0 : r_step + 1'b1;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end
            // Boundary loads the pre-write shadow; a same-cycle write then lands on top
            if (w_bnd && r_pend) begin
                r_act  <= r_shd;
                r_pend <= 1'b0;
            end
            if (i_wr_vld) begin
                r_shd <= i_wr_dat;
                if (i_wr_imm) begin
                    r_act   <= i_wr_dat;
                    r_pend  <= 1'b0;
                    r_presc <= '0;
                    r_step  <= STEP_INIT;
                end else begin
                    r_pend <= 1'b1;
                end
            end
        end
    end

    assign o_pwm    = r_pwm;
    assign o_pend   = r_pend;
    assign o_period = w_bnd & ~(i_wr_vld & i_wr_imm);

endmodule

// File: rtl/pwm_bank_ctrl.sv
// N_CH-channel PWM bank: validates commands and fans them out to per-channel timebases.
// Latency: accepted command affects channel state next cycle; reject pulses cmd_err next cycle.
// Backpressure: none, cmd_ready = rstn; PWM_BANK_PHASE_STAGGER_EN staggers channel start phase.
module pwm_bank_ctrl
    import pwm_bank_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BASE_FREQ = 100,
    parameter int N_CH      = 4,
    parameter int DIV_W     = 16
) (
    input  logic              clk,
    input  logic              rstn,
    pwm_bank_ctrl_if.slave    cmd,
    input  logic              global_en,
    output logic [N_CH-1:0]   pwm_o,
    output logic [N_CH-1:0]   pend_o,
    output logic [N_CH-1:0]   period_o
);

    localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);

    logic w_bad;
    logic w_acc;
    logic r_err;
    cmd_t w_cmd;

    assign w_bad = ({1'b0, cmd.cmd_ch} >= N_CH_L) || (cmd.cmd_duty > DUTY_W'(STEPS));
    assign w_acc = cmd.cmd_valid & rstn & ~w_bad;
    assign w_cmd = '{duty: cmd.cmd_duty, pow2: cmd.cmd_pow2, pow5: cmd.cmd_pow5};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else begin
            r_err <= cmd.cmd_valid & w_bad;
        end
    end

    assign cmd.cmd_ready = rstn;
    assign cmd.cmd_err   = r_err;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pwm_channel #(
            .CLK_FREQ  (CLK_FREQ),
            .BASE_FREQ (BASE_FREQ),
            .DIV_W     (DIV_W),
            .N_CH      (N_CH),
            .IDX       (i)
        ) u_ch (
            .clk      (clk),
            .rstn     (rstn),
            .i_en     (global_en),
            .i_wr_vld (w_acc && (cmd.cmd_ch == CH_W'(i))),
            .i_wr_imm (cmd.cmd_imm),
            .i_wr_dat (w_cmd),
            .o_pwm    (pwm_o[i]),
            .o_pend   (pend_o[i]),
            .o_period (period_o[i])
        );
    end

endmodule

// File: tb/tb_pwm_bank_ctrl.sv
// Directed bench for pwm_bank_ctrl at CLK_FREQ=8000, BASE_FREQ=1, N_CH=4 (DIV(0,0)=80, DIV(3,0)=10).
// Sample index k counts clock edges since the command edge that started the scenario.
module tb_pwm_bank_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       global_en;
    logic [3:0] pwm_o;
    logic [3:0] pend_o;
    logic [3:0] period_o;
    int         n_pass = 0;
    int         n_total = 0;

    pwm_bank_ctrl_if cmd_if ();

    pwm_bank_ctrl #(
        .CLK_FREQ  (8000),
        .BASE_FREQ (1),
        .N_CH      (4),
        .DIV_W     (16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd       (cmd_if),
        .global_en (global_en),
        .pwm_o     (pwm_o),
        .pend_o    (pend_o),
        .period_o  (period_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input int duty, input int p2, input int p5, input bit imm);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_ch    = 4'(ch);
        cmd_if.cmd_duty  = 7'(duty);
        cmd_if.cmd_pow2  = 2'(p2);
        cmd_if.cmd_pow5  = 2'(p5);
        cmd_if.cmd_imm   = imm;
        tick(1);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick(3);
        n_total++; if (pwm_o !== 4'h0) $display("FAIL rst_pwm got %h exp 0", pwm_o); else n_pass++;
        n_total++; if (pend_o !== 4'h0) $display("FAIL rst_pend got %h exp 0", pend_o); else n_pass++;
        n_total++; if (period_o !== 4'h0) $display("FAIL rst_period got %h exp 0", period_o); else n_pass++;
        n_total++; if (cmd_if.cmd_err !== 1'b0) $display("FAIL rst_err got %b exp 0", cmd_if.cmd_err); else n_pass++;
        n_total++; if (cmd_if.cmd_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", cmd_if.cmd_ready); else n_pass++;
        rstn = 1'b1;
        tick(1);
        n_total++; if (cmd_if.cmd_ready !== 1'b1) $display("FAIL run_ready got %b exp 1", cmd_if.cmd_ready); else n_pass++;
    endtask

    task automatic test_imm();
        int hi = 0;
        int fall = 0;
        int np = 0;
        send(0, 25, 0, 0, 1'b1);
        n_total++; if (pwm_o[0] !== 1'b0) $display("FAIL imm_lag got %b exp 0", pwm_o[0]); else n_pass++;
        for (int k = 1; k <= 8000; k++) begin
            tick(1);
            if (pwm_o[0]) hi++;
            else if (fall == 0 && hi > 0) fall = k;
            if (period_o[0]) np++;
        end
        n_total++; if (hi !== 2000) $display("FAIL imm_high got %0d exp 2000", hi); else n_pass++;
        n_total++; if (fall !== 2001) $display("FAIL imm_fall got %0d exp 2001", fall); else n_pass++;
        n_total++; if (np !== 1) $display("FAIL imm_periods got %0d exp 1", np); else n_pass++;
        n_total++; if (pend_o[0] !== 1'b0) $display("FAIL imm_pend got %b exp 0", pend_o[0]); else n_pass++;
    endtask

    task automatic test_shadow();
        int n = 0;
        int hi = 0;
        send(1, 50, 0, 0, 1'b1);
        tick(1000);
        send(1, 10, 0, 0, 1'b0);
        n_total++; if (pend_o[1] !== 1'b1) $display("FAIL shd_pend_set got %b exp 1", pend_o[1]); else n_pass++;
        while (!period_o[1] && n < 9000) begin
            tick(1);
            n++;
        end
        n_total++; if (n !== 6998) $display("FAIL shd_bnd_wait got %0d exp 6998", n); else n_pass++;
        n_total++; if (pend_o[1] !== 1'b1) $display("FAIL shd_pend_bnd got %b exp 1", pend_o[1]); else n_pass++;
        tick(1);
        n_total++; if (pend_o[1] !== 1'b0) $display("FAIL shd_pend_clr got %b exp 0", pend_o[1]); else n_pass++;
        for (int k = 0; k < 8000; k++) begin
            tick(1);
            if (pwm_o[1]) hi++;
        end
        n_total++; if (hi !== 800) $display("FAIL shd_high got %0d exp 800", hi); else n_pass++;
    endtask

    task automatic test_reject();
        send(5, 50, 0, 0, 1'b0);
        n_total++; if (cmd_if.cmd_err !== 1'b1) $display("FAIL rej_ch_err got %b exp 1", cmd_if.cmd_err); else n_pass++;
        tick(1);
        n_total++; if (cmd_if.cmd_err !== 1'b0) $display("FAIL rej_ch_pulse got %b exp 0", cmd_if.cmd_err); else n_pass++;
        n_total++; if (pend_o !== 4'h0) $display("FAIL rej_ch_pend got %h exp 0", pend_o); else n_pass++;
        send(2, 101, 0, 0, 1'b1);
        n_total++; if (cmd_if.cmd_err !== 1'b1) $display("FAIL rej_duty_err got %b exp 1", cmd_if.cmd_err); else n_pass++;
        tick(2);
        n_total++; if (cmd_if.cmd_err !== 1'b0) $display("FAIL rej_duty_pulse got %b exp 0", cmd_if.cmd_err); else n_pass++;
        n_total++; if (pwm_o[3:2] !== 2'b00) $display("FAIL rej_duty_pwm got %b exp 00", pwm_o[3:2]); else n_pass++;
        n_total++; if (pend_o !== 4'h0) $display("FAIL rej_duty_pend got %h exp 0", pend_o); else n_pass++;
    endtask

    task automatic test_pow2();
        int n = 0;
        int lo = 0;
        int hi = 0;
        int np = 0;
        send(2, 100, 3, 0, 1'b1);
        n_total++; if (pwm_o[2] !== 1'b0) $display("FAIL p2_lag got %b exp 0", pwm_o[2]); else n_pass++;
        tick(1);
        n_total++; if (pwm_o[2] !== 1'b1) $display("FAIL p2_high got %b exp 1", pwm_o[2]); else n_pass++;
        send(2, 0, 3, 0, 1'b0);
        n_total++; if (cmd_if.cmd_err !== 1'b0) $display("FAIL p2_err got %b exp 0", cmd_if.cmd_err); else n_pass++;
        while (!period_o[2] && n < 2000) begin
            if (!pwm_o[2]) lo++;
            tick(1);
            n++;
        end
        n_total++; if (n !== 997) $display("FAIL p2_bnd_wait got %0d exp 997", n); else n_pass++;
        n_total++; if (lo !== 0) $display("FAIL p2_const_high got %0d lows exp 0", lo); else n_pass++;
        tick(1);
        n_total++; if (pwm_o[2] !== 1'b1) $display("FAIL p2_last_high got %b exp 1", pwm_o[2]); else n_pass++;
        tick(1);
        n_total++; if (pwm_o[2] !== 1'b0) $display("FAIL p2_low got %b exp 0", pwm_o[2]); else n_pass++;
        for (int k = 0; k < 1000; k++) begin
            tick(1);
            if (pwm_o[2]) hi++;
            if (period_o[2]) np++;
        end
        n_total++; if (hi !== 0) $display("FAIL p2_const_low got %0d highs exp 0", hi); else n_pass++;
        n_total++; if (np !== 1) $display("FAIL p2_period got %0d pulses exp 1", np); else n_pass++;
    endtask

    task automatic test_bnd_write();
        int n = 0;
        int hi = 0;
        send(3, 20, 0, 0, 1'b1);
        send(3, 10, 0, 0, 1'b0);
        send(3, 40, 0, 0, 1'b0);
        while (!period_o[3] && n < 9000) begin
            tick(1);
            n++;
        end
        n_total++; if (n !== 7997) $display("FAIL bw_bnd_wait got %0d exp 7997", n); else n_pass++;
        send(3, 60, 0, 0, 1'b0);
        n_total++; if (pend_o[3] !== 1'b1) $display("FAIL bw_pend_kept got %b exp 1", pend_o[3]); else n_pass++;
        for (int k = 0; k < 8000; k++) begin
            tick(1);
            if (pwm_o[3]) hi++;
        end
        n_total++; if (hi !== 3200) $display("FAIL bw_old_shadow got %0d exp 3200", hi); else n_pass++;
        n_total++; if (pend_o[3] !== 1'b0) $display("FAIL bw_pend_clr got %b exp 0", pend_o[3]); else n_pass++;
        hi = 0;
        for (int k = 0; k < 8000; k++) begin
            tick(1);
            if (pwm_o[3]) hi++;
        end
        n_total++; if (hi !== 4800) $display("FAIL bw_new_duty got %0d exp 4800", hi); else n_pass++;
    endtask

    task automatic test_global_en();
        int act = 0;
        int n = 0;
        send(0, 25, 0, 0, 1'b1);
        tick(1000);
        global_en = 1'b0;
        send(1, 70, 0, 0, 1'b0);
        n_total++; if (pwm_o !== 4'h0) $display("FAIL ge_pwm_off got %h exp 0", pwm_o); else n_pass++;
        for (int k = 0; k < 499; k++) begin
            tick(1);
            act += $countones(pwm_o) + $countones(period_o);
        end
        n_total++; if (act !== 0) $display("FAIL ge_quiet got %0d exp 0", act); else n_pass++;
        n_total++; if (pend_o[1] !== 1'b1) $display("FAIL ge_cmd_accept got %b exp 1", pend_o[1]); else n_pass++;
        global_en = 1'b1;
        tick(1);
        n_total++; if (pwm_o[0] !== 1'b1) $display("FAIL ge_resume got %b exp 1", pwm_o[0]); else n_pass++;
        while (!period_o[0] && n < 9000) begin
            tick(1);
            n++;
        end
        n_total++; if (n !== 6998) $display("FAIL ge_stretch got %0d exp 6998", n); else n_pass++;
    endtask

    task automatic test_reset_mid();
        send(0, 100, 0, 0, 1'b1);
        send(2, 30, 0, 0, 1'b0);
        n_total++; if (pwm_o[0] !== 1'b1) $display("FAIL rm_pre_high got %b exp 1", pwm_o[0]); else n_pass++;
        n_total++; if (pend_o[2] !== 1'b1) $display("FAIL rm_pre_pend got %b exp 1", pend_o[2]); else n_pass++;
        rstn = 1'b0;
        tick(1);
        n_total++; if (pwm_o !== 4'h0) $display("FAIL rm_pwm got %h exp 0", pwm_o); else n_pass++;
        n_total++; if (pend_o !== 4'h0) $display("FAIL rm_pend got %h exp 0", pend_o); else n_pass++;
        n_total++; if (cmd_if.cmd_ready !== 1'b0) $display("FAIL rm_ready got %b exp 0", cmd_if.cmd_ready); else n_pass++;
        rstn = 1'b1;
        tick(3);
        n_total++; if (pwm_o[0] !== 1'b0) $display("FAIL rm_duty_cleared got %b exp 0", pwm_o[0]); else n_pass++;
    endtask

    initial begin
        rstn              = 1'b0;
        global_en         = 1'b1;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_ch     = '0;
        cmd_if.cmd_duty   = '0;
        cmd_if.cmd_pow2   = '0;
        cmd_if.cmd_pow5   = '0;
        cmd_if.cmd_imm    = 1'b0;
        test_reset();
        test_imm();
        test_shadow();
        test_reject();
        test_pow2();
        test_bnd_write();
        test_global_en();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
